// File: rtl/wbaq_pkg.sv
// Shared definitions for the writeback store queue: size codes, line geometry,
// FSM encoding, queue entry layout and the line-crossing helper.
package wbaq_pkg;

    localparam int unsigned LINE_BYTES = 16;

    localparam logic [1:0] SZ_1B = 2'b00;
    localparam logic [1:0] SZ_2B = 2'b01;
    localparam logic [1:0] SZ_4B = 2'b10;
    localparam logic [1:0] SZ_8B = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_LO = 2'd1,
        ST_REQ_HI = 2'd2
    } wbaq_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        logic [6:0]  ptcid;
    } wbaq_entry_t;

    // True when an access of 2**size bytes at line offset off spills into the next line.
    function automatic logic crosses(input logic [3:0] off, input logic [1:0] size);
        return (5'(off) + (5'd1 << size)) > 5'(LINE_BYTES);
    endfunction

endpackage

// File: rtl/wbaq_split.sv
// Places a store into 16-byte line form: rotated data and the byte enables for
// either the first (hi=0) or the spill-over (hi=1) line.
module wbaq_split
    import wbaq_pkg::*;
(
    input  logic [3:0]   addr_lo,
    input  logic [1:0]   size,
    input  logic [63:0]  data,
    input  logic         hi,
    output logic [127:0] data128,
    output logic [15:0]  mask16
);

    logic [3:0]   nbytes;
    logic [31:0]  span;
    logic [255:0] rot;

    always_comb begin
        case (size)
            SZ_1B:   nbytes = 4'd1;
            SZ_2B:   nbytes = 4'd2;
            SZ_4B:   nbytes = 4'd4;
            SZ_8B:   nbytes = 4'd8;
            default: nbytes = 4'd8;
        endcase
        // Byte enables over two consecutive lines; upper half is the spill-over line.
        span    = ((32'd1 << nbytes) - 32'd1) << addr_lo;
        mask16  = hi ? span[31:16] : span[15:0];
        // Doubling the operand turns the left shift into a 128-bit rotate.
        rot     = {64'd0, data, 64'd0, data} << {addr_lo, 3'b000};
        data128 = rot[255:128];
    end

endmodule

// File: rtl/wbaq_ctrl.sv
// Writeback store queue: buffers stores from writeback and issues them to the
// cache as line-aligned writes, splitting stores that cross a 16-byte line.
module wbaq_ctrl
    import wbaq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb_valid,
    input  logic [31:0]  wb_addr,
    input  logic [63:0]  wb_data,
    input  logic [1:0]   wb_size,
    input  logic [6:0]   wb_ptcid,
    output logic         full,
    output logic         empty,
    output logic [3:0]   count,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_data,
    output logic [15:0]  mem_mask,
    output logic [6:0]   mem_ptcid,
    input  logic         mem_ack,
    input  logic [31:0]  ld_addr,
    output logic         ld_conflict
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    wbaq_entry_t      ent_q [DEPTH];
    wbaq_entry_t      wr_ent;
    wbaq_entry_t      head_ent;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    wbaq_state_e      state_q, state_d;
    logic             push;
    logic             pop;
    logic             split_hi;
    logic             hd_cross;

    assign wr_ent   = '{addr: wb_addr, data: wb_data, size: wb_size, ptcid: wb_ptcid};
    assign head_ent = ent_q[head_q];
    assign hd_cross = crosses(head_ent.addr[3:0], head_ent.size);

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign push  = wb_valid && !full;

    // Payload storage is written only at the tail and never needs clearing.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_q[tail_q] <= wr_ent;
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a push into an empty queue is requested on the following cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (count_q != '0 || push) state_d = ST_REQ_LO;
            ST_REQ_LO: if (mem_ack) state_d = hd_cross ? ST_REQ_HI : ST_IDLE;
            ST_REQ_HI: if (mem_ack) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_req  = 1'b0;
        split_hi = 1'b0;
        pop      = 1'b0;
        case (state_q)
            ST_REQ_LO: begin
                mem_req = 1'b1;
                pop     = mem_ack && !hd_cross;
            end
            ST_REQ_HI: begin
                mem_req  = 1'b1;
                split_hi = 1'b1;
                pop      = mem_ack;
            end
            default: ;
        endcase
    end

    wbaq_split u_split (
        .addr_lo (head_ent.addr[3:0]),
        .size    (head_ent.size),
        .data    (head_ent.data),
        .hi      (split_hi),
        .data128 (mem_data),
        .mask16  (mem_mask)
    );

    assign mem_addr  = split_hi ? ({head_ent.addr[31:4], 4'h0} + 32'(LINE_BYTES))
                                : {head_ent.addr[31:4], 4'h0};
    assign mem_ptcid = head_ent.ptcid;

    // Match on line address by comparing everything above the byte offset.
    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & 32'hFFFF_FFF0) == 32'h0;
    endfunction

    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q) begin
                if (same_line(ent_q[i].addr, ld_addr)) begin
                    ld_conflict = 1'b1;
                end
                if (crosses(ent_q[i].addr[3:0], ent_q[i].size) &&
                    same_line({ent_q[i].addr[31:4] + 28'd1, 4'h0}, ld_addr)) begin
                    ld_conflict = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wbaq_ctrl.sv
// Directed bench for wbaq_ctrl with hand-computed expectations (DEPTH=4).
module tb_wbaq_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wb_valid = 1'b0;
    logic [31:0]  wb_addr = '0;
    logic [63:0]  wb_data = '0;
    logic [1:0]   wb_size = '0;
    logic [6:0]   wb_ptcid = '0;
    logic         full, empty, mem_req, ld_conflict;
    logic [3:0]   count;
    logic [31:0]  mem_addr;
    logic [127:0] mem_data;
    logic [15:0]  mem_mask;
    logic [6:0]   mem_ptcid;
    logic         mem_ack = 1'b0;
    logic [31:0]  ld_addr = '0;

    int vecs = 0;
    int errs = 0;

    wbaq_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_size(wb_size), .wb_ptcid(wb_ptcid),
        .full(full), .empty(empty), .count(count),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_mask(mem_mask), .mem_ptcid(mem_ptcid), .mem_ack(mem_ack),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] a, input logic [1:0] s,
                           input logic [63:0] d, input logic [6:0] p);
        wb_addr = a; wb_size = s; wb_data = d; wb_ptcid = p; wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        mem_ack = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (empty) done = 1'b1;
            else step();
        end
        mem_ack = 1'b0;
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL %s_drain: empty=%0b want 1 (timeout)", tag, empty); end
    endtask

    task automatic test_reset();
        #2;
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_mem_req: got %0b want 0", mem_req); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL rst_empty: got %0b want 1", empty); end
        vecs++; if (full !== 1'b0) begin errs++; $display("FAIL rst_full: got %0b want 0", full); end
        vecs++; if (count !== 4'd0) begin errs++; $display("FAIL rst_count: got %0d want 0", count); end
        vecs++; if (ld_conflict !== 1'b0) begin errs++; $display("FAIL rst_ld_conflict: got %0b want 0", ld_conflict); end
        step(); step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_aligned();
        do_push(32'h0000_1004, 2'b10, 64'hDDCC_BBAA, 7'd5);
        vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL al_req: got %0b want 1", mem_req); end
        vecs++; if (mem_addr !== 32'h1000) begin errs++; $display("FAIL al_addr: got %h want 00001000", mem_addr); end
        vecs++; if (mem_mask !== 16'h00F0) begin errs++; $display("FAIL al_mask: got %h want 00f0", mem_mask); end
        vecs++; if (mem_data !== 128'hDDCCBBAA_00000000) begin errs++; $display("FAIL al_data: got %h want ddccbbaa00000000", mem_data); end
        vecs++; if (mem_ptcid !== 7'd5) begin errs++; $display("FAIL al_ptcid: got %0d want 5", mem_ptcid); end
        vecs++; if (count !== 4'd1) begin errs++; $display("FAIL al_count: got %0d want 1", count); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL al_pop_empty: got %0b want 1", empty); end
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL al_pop_req: got %0b want 0", mem_req); end
    endtask

    task automatic test_split();
        do_push(32'h0000_200C, 2'b11, 64'h8877_6655_4433_2211, 7'd9);
        vecs++; if (mem_mask !== 16'hF000) begin errs++; $display("FAIL sp_lo_mask: got %h want f000", mem_mask); end
        vecs++; if (mem_addr !== 32'h2000) begin errs++; $display("FAIL sp_lo_addr: got %h want 00002000", mem_addr); end
        vecs++; if (mem_data !== 128'h44332211_00000000_00000000_88776655) begin errs++; $display("FAIL sp_data: got %h", mem_data); end
        step();
        vecs++; if (mem_req !== 1'b1 || mem_mask !== 16'hF000) begin errs++; $display("FAIL sp_hold: req=%0b mask=%h want 1 f000", mem_req, mem_mask); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        vecs++; if (mem_mask !== 16'h000F) begin errs++; $display("FAIL sp_hi_mask: got %h want 000f", mem_mask); end
        vecs++; if (mem_addr !== 32'h2010) begin errs++; $display("FAIL sp_hi_addr: got %h want 00002010", mem_addr); end
        vecs++; if (count !== 4'd1 || mem_req !== 1'b1) begin errs++; $display("FAIL sp_hi_count: count=%0d req=%0b want 1 1", count, mem_req); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL sp_pop: empty=%0b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        do_push(32'h0000_5001, 2'b00, 64'hA1, 7'd1);
        do_push(32'h0000_5012, 2'b01, 64'hBEEF, 7'd2);
        do_push(32'h0000_502E, 2'b10, 64'h1234_5678, 7'd3);
        vecs++; if (count !== 4'd3 || mem_addr !== 32'h5000 || mem_mask !== 16'h0002) begin errs++; $display("FAIL b2b_a: count=%0d addr=%h mask=%h want 3 00005000 0002", count, mem_addr, mem_mask); end
        vecs++; if (mem_data !== 128'hA100) begin errs++; $display("FAIL b2b_a_data: got %h want a100", mem_data); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        step();
        vecs++; if (mem_addr !== 32'h5010 || mem_mask !== 16'h000C || mem_ptcid !== 7'd2) begin errs++; $display("FAIL b2b_b: addr=%h mask=%h ptcid=%0d want 00005010 000c 2", mem_addr, mem_mask, mem_ptcid); end
        vecs++; if (mem_data !== 128'hBEEF0000) begin errs++; $display("FAIL b2b_b_data: got %h want beef0000", mem_data); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        step();
        vecs++; if (mem_addr !== 32'h5020 || mem_mask !== 16'hC000) begin errs++; $display("FAIL b2b_c_lo: addr=%h mask=%h want 00005020 c000", mem_addr, mem_mask); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        vecs++; if (mem_addr !== 32'h5030 || mem_mask !== 16'h0003) begin errs++; $display("FAIL b2b_c_hi: addr=%h mask=%h want 00005030 0003", mem_addr, mem_mask); end
        drain("b2b");
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            wb_addr = 32'h4000 + 32'(i * 16); wb_size = 2'b00; wb_data = 64'(i); wb_ptcid = 7'(i);
            wb_valid = 1'b1;
            step();
            vecs++; if (count !== 4'((i < 4) ? i + 1 : 4)) begin errs++; $display("FAIL full_count%0d: got %0d want %0d", i, count, (i < 4) ? i + 1 : 4); end
        end
        wb_valid = 1'b0;
        vecs++; if (full !== 1'b1) begin errs++; $display("FAIL full_flag: got %0b want 1", full); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        vecs++; if (full !== 1'b0 || count !== 4'd3) begin errs++; $display("FAIL full_ack: full=%0b count=%0d want 0 3", full, count); end
        step();
        vecs++; if (mem_addr !== 32'h4010) begin errs++; $display("FAIL full_next_head: got %h want 00004010", mem_addr); end
        drain("full");
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 4; i++) do_push(32'h6000 + 32'(i * 16), 2'b00, 64'(i), 7'd0);
        vecs++; if (full !== 1'b1 || mem_req !== 1'b1) begin errs++; $display("FAIL pp_pre: full=%0b req=%0b want 1 1", full, mem_req); end
        wb_addr = 32'h6040; wb_valid = 1'b1; mem_ack = 1'b1;
        step();
        wb_valid = 1'b0; mem_ack = 1'b0;
        vecs++; if (count !== 4'd3 || full !== 1'b0) begin errs++; $display("FAIL pp_count: count=%0d full=%0b want 3 0", count, full); end
        drain("pp");
    endtask

    task automatic test_conflict();
        do_push(32'h0000_300F, 2'b01, 64'hCAFE, 7'd4);
        ld_addr = 32'h3010; #1;
        vecs++; if (ld_conflict !== 1'b1) begin errs++; $display("FAIL cf_second_line: got %0b want 1", ld_conflict); end
        ld_addr = 32'h3008; #1;
        vecs++; if (ld_conflict !== 1'b1) begin errs++; $display("FAIL cf_first_line: got %0b want 1", ld_conflict); end
        ld_addr = 32'h3020; #1;
        vecs++; if (ld_conflict !== 1'b0) begin errs++; $display("FAIL cf_other_line: got %0b want 0", ld_conflict); end
        vecs++; if (mem_mask !== 16'h8000) begin errs++; $display("FAIL cf_lo_mask: got %h want 8000", mem_mask); end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        vecs++; if (mem_mask !== 16'h0001 || mem_addr !== 32'h3010) begin errs++; $display("FAIL cf_hi: mask=%h addr=%h want 0001 00003010", mem_mask, mem_addr); end
        ld_addr = 32'h3010; mem_ack = 1'b1; #1;
        vecs++; if (ld_conflict !== 1'b1) begin errs++; $display("FAIL cf_popping: got %0b want 1", ld_conflict); end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_midflight();
        #1;
        rst = 1'b0;
        #1;
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL mid_rst_req: got %0b want 0", mem_req); end
        vecs++; if (empty !== 1'b1 || count !== 4'd0) begin errs++; $display("FAIL mid_rst_empty: empty=%0b count=%0d want 1 0", empty, count); end
        vecs++; if (ld_conflict !== 1'b0) begin errs++; $display("FAIL mid_rst_conflict: got %0b want 0", ld_conflict); end
        step();
        rst = 1'b1;
        step(); step();
        vecs++; if (mem_req !== 1'b0 || empty !== 1'b1) begin errs++; $display("FAIL post_rst: req=%0b empty=%0b want 0 1", mem_req, empty); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_split();
        test_back_to_back();
        test_full();
        test_push_pop_full();
        test_conflict();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/wbaq_ctrl.md
WBAQ_CTRL -- requirements
Module: wbaq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries (power of two, 2..8).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wb_valid  in  1  writeback memory-store strobe (writeback mem_ld).
REQ-005 SHALL have port wb_addr  in  32  store byte address.
REQ-006 SHALL have port wb_data  in  64  store data, little-endian, byte 0 at wb_data[7:0].
REQ-007 SHALL have port wb_size  in  2  00=1B, 01=2B, 10=4B, 11=8B.
REQ-008 SHALL have port wb_ptcid  in  7  protection-check id of the store.
REQ-009 SHALL have port full  out  1  to writeback wbaq_full.
REQ-010 SHALL have port empty  out  1  queue holds no entries.
REQ-011 SHALL have port count  out  4  valid entries.
REQ-012 SHALL have port mem_req  out  1  cache write request.
REQ-013 SHALL have port mem_addr  out  32  16B-line address, bits[3:0]=0.
REQ-014 SHALL have port mem_data  out  128  line-aligned store data.
REQ-015 SHALL have port mem_mask  out  16  byte enables within line.
REQ-016 SHALL have port mem_ptcid  out  7  ptcid of head entry.
REQ-017 SHALL have port mem_ack  in  1  cache accepts request this cycle.
REQ-018 SHALL have port ld_addr  in  32  load address for conflict check.
REQ-019 SHALL have port ld_conflict  out  1  any valid entry touches ld_addr's 16B line.

Function
REQ-020 SHALL enqueue {addr,data,size,ptcid} at tail on a rising edge where wb_valid=1 and full=0; wb_valid while full=1 SHALL be ignored.
REQ-021 SHALL drive full=1 iff registered count==DEPTH; a pop in the same cycle SHALL NOT admit a push while full=1.
REQ-022 SHALL drive empty=1 iff count==0; simultaneous push and pop SHALL leave count unchanged.
REQ-023 SHALL wrap head/tail pointers modulo DEPTH.
REQ-024 SHALL implement FSM IDLE, REQ_LO, REQ_HI: IDLE->REQ_LO when count>0; REQ_LO->IDLE on mem_ack if access fits in line; REQ_LO->REQ_HI on mem_ack if it crosses; REQ_HI->IDLE on mem_ack.
REQ-025 SHALL assert mem_req combinationally in REQ_LO and REQ_HI only; outputs SHALL hold stable until mem_ack.
REQ-026 SHALL define n=1<<size bytes, off=addr[3:0]; crossing iff off+n>16.
REQ-027 SHALL drive mem_data = zero-extended 64b data rotated left by 8*off bits over 128 bits, identical in both halves.
REQ-028 SHALL drive mem_mask in REQ_LO = bits off..min(off+n,16)-1; in REQ_HI = bits 0..(off+n-17); mem_addr = {addr[31:4],4'h0} in REQ_LO, that +16 (32b wrap) in REQ_HI.
REQ-029 SHALL pop head on the edge of the final mem_ack of an entry; min latency push->mem_req SHALL be 1 cycle.
REQ-030 SHALL assert ld_conflict combinationally iff some valid entry's first or (if crossing) second line equals ld_addr[31:4]; entry being popped still counts that cycle.
REQ-031 SHALL ignore mem_ack when mem_req=0.

Reset
REQ-032 SHALL on rst=0 immediately clear pointers, count=0, state=IDLE, mem_req=0, full=0, empty=1, ld_conflict=0; in-flight split requests SHALL be abandoned.
REQ-033 Entry payload storage SHALL NOT require reset.

Structure
REQ-034 Shared package SHALL hold size encodings, LINE_BYTES=16, FSM state encoding.
REQ-035 Rotate/mask generation SHALL be one combinational sub-module wbaq_split (inputs addr[3:0], size, data, hi; outputs data128, mask16).

Verification
REQ-036 Reset then push addr=0x1004,size=10,data=0xDDCCBBAA -> next cycle mem_req=1, mem_addr=0x1000, mask=0x00F0, data[63:32]=0xDDCCBBAA.
REQ-037 Push addr=0x200C,size=11 -> REQ_LO mask=0xF000 addr=0x2000; after ack REQ_HI mask=0x000F addr=0x2010; pop after second ack.
REQ-038 DEPTH=4, mem_ack=0, five pushes -> full=1 after 4th, 5th dropped, count=4; ack one -> full=0 next cycle.
REQ-039 Full queue, push+ack same cycle -> push dropped, count=3.
REQ-040 Entry 0x300F size 01 queued; ld_addr=0x3010 -> ld_conflict=1; ld_addr=0x3020 -> 0.
REQ-041 rst=0 asserted while in REQ_HI -> mem_req=0, empty=1 without clock edge.
